// File: rtl/inst_mem_boot.sv
// inst_mem_boot: boot-loadable instruction SRAM with a LOAD/RUN controller and a registered fetch port
module inst_mem_boot #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 128,
  parameter int ADX_LENGTH = 7,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  input  logic                  reload,
  input  logic                  fetch_en,
  input  logic [ADX_LENGTH-1:0] adx,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  running,
  output logic [ADX_LENGTH:0]   words_loaded
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [ADX_LENGTH:0] DEPTH_W = (ADX_LENGTH+1)'(DEPTH);
  localparam logic [ADX_LENGTH:0] LAST_CNT = (ADX_LENGTH+1)'(DEPTH-1);
  typedef enum logic {LOAD, RUN} state_t;
  state_t state, state_nxt;
  logic [ADX_LENGTH:0] load_cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic accept, fetch;
  assign load_ready = state == LOAD;
  assign running = state == RUN;
  assign accept = load_valid & load_ready;
  assign fetch = running & fetch_en & ~reload;
  always_ff @(posedge clk)
    state <= rst ? LOAD : state_nxt;
  always_comb begin
    state_nxt = state;
    state_nxt = (state == LOAD) ? ((accept && (load_last || load_cnt == LAST_CNT)) ? RUN : LOAD)
                                : (reload ? LOAD : RUN);
  end
  // SRAM is never reset; contents survive rst and reload
  always_ff @(posedge clk)
    if (accept && !rst) mem[load_cnt[AW-1:0]] <= load_data;
  always_ff @(posedge clk)
    if (rst) begin
      load_cnt <= '0;
      words_loaded <= '0;
      rd_valid <= 1'b0;
      rd_data <= NOP_WORD;
    end else begin
      if (accept) begin
        load_cnt <= load_cnt + 1'b1;
        words_loaded <= load_cnt + 1'b1;
      end else if (running && reload) begin
        load_cnt <= '0;
        words_loaded <= '0;
      end
      rd_valid <= fetch;
      if (fetch) rd_data <= ({1'b0, adx} < DEPTH_W) ? mem[adx[AW-1:0]] : NOP_WORD;
    end
endmodule

// File: tb/tb_inst_mem_boot.sv
// tb_inst_mem_boot: directed checks of boot load, fetch, reload and reset on default and shallow instances
module tb_inst_mem_boot;
  logic clk = 0, rst = 0, load_valid = 0, load_last = 0, reload = 0, fetch_en = 0;
  logic [31:0] load_data = 0;
  logic [6:0] adx = 0;
  logic a_ready, a_valid, a_running, b_ready, b_valid, b_running;
  logic [31:0] a_data, b_data;
  logic [7:0] a_words, b_words;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  inst_mem_boot dut_a (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(a_ready), .reload(reload), .fetch_en(fetch_en), .adx(adx), .rd_data(a_data),
    .rd_valid(a_valid), .running(a_running), .words_loaded(a_words)
  );

  inst_mem_boot #(.DEPTH(100), .NOP_WORD(32'h13)) dut_b (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(b_ready), .reload(reload), .fetch_en(fetch_en), .adx(adx), .rd_data(b_data),
    .rd_valid(b_valid), .running(b_running), .words_loaded(b_words)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] d, input logic last);
    load_valid = 1;
    load_data = d;
    load_last = last;
    step();
    load_valid = 0;
    load_last = 0;
  endtask

  task automatic fetch_chk(input string tag, input logic [6:0] a, input logic [31:0] exp);
    fetch_en = 1;
    adx = a;
    step();
    fetch_en = 0;
    chk({tag, "_valid"}, a_valid, 1);
    chk(tag, a_data, exp);
  endtask

  initial begin
    rst = 1;
    step();
    rst = 0;
    chk("rst_running", a_running, 0);
    chk("rst_ready", a_ready, 1);
    chk("rst_words", a_words, 0);
    chk("rst_valid", a_valid, 0);
    chk("rst_data", a_data, 0);
    chk("rst_data_b", b_data, 32'h13);
    // fetch held through the whole load with gaps between words
    fetch_en = 1;
    adx = 1;
    load_word(32'h11, 0);
    fetch_en = 1;
    step();
    chk("gap_words", a_words, 1);
    chk("load_fetch_valid", a_valid, 0);
    load_word(32'h22, 0);
    fetch_en = 1;
    step();
    chk("gap_words2", a_words, 2);
    load_word(32'h33, 1);
    chk("last_running", a_running, 1);
    chk("last_ready", a_ready, 0);
    chk("last_words", a_words, 3);
    chk("last_valid", a_valid, 0);
    fetch_chk("fetch1", 1, 32'h22);
    step();
    chk("idle_valid", a_valid, 0);
    chk("idle_hold", a_data, 32'h22);
    // reload beats fetch on the same edge
    reload = 1;
    fetch_en = 1;
    adx = 0;
    step();
    chk("reload_valid", a_valid, 0);
    chk("reload_ready", a_ready, 1);
    chk("reload_words", a_words, 0);
    fetch_en = 0;
    step();
    reload = 0;
    chk("reload_in_load", a_running, 0);
    load_word(32'hAA, 1);
    chk("reload_words1", a_words, 1);
    fetch_chk("reload_adx0", 0, 32'hAA);
    fetch_chk("reload_adx1", 1, 32'h22);
    fetch_chk("reload_adx2", 2, 32'h33);
    // reset in the middle of a partial image
    rst = 1;
    step();
    rst = 0;
    load_word(32'h51, 0);
    load_word(32'h52, 0);
    rst = 1;
    step();
    rst = 0;
    chk("abort_words", a_words, 0);
    chk("abort_running", a_running, 0);
    load_word(32'h61, 1);
    fetch_chk("abort_adx0", 0, 32'h61);
    fetch_chk("abort_adx1", 1, 32'h52);
    // full-depth image with no load_last
    reload = 1;
    step();
    reload = 0;
    for (int i = 0; i < 127; i++) load_word(i * 3 + 1, 0);
    chk("full_127_words", a_words, 127);
    chk("full_127_running", a_running, 0);
    chk("b_words", b_words, 100);
    chk("b_running", b_running, 1);
    load_word(127 * 3 + 1, 0);
    chk("full_running", a_running, 1);
    chk("full_ready", a_ready, 0);
    chk("full_words", a_words, 128);
    load_word(32'hDEAD, 0);
    load_word(32'hBEEF, 1);
    chk("extra_words", a_words, 128);
    fetch_chk("full_adx127", 127, 127 * 3 + 1);
    chk("b_nop_valid", b_valid, 1);
    chk("b_nop", b_data, 32'h13);
    fetch_chk("full_adx0", 0, 1);
    fetch_en = 1;
    adx = 99;
    step();
    fetch_en = 0;
    chk("b_adx99_valid", b_valid, 1);
    chk("b_adx99", b_data, 99 * 3 + 1);
    chk("a_adx99", a_data, 99 * 3 + 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
